// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - two-master round-robin peripheral bus arbiter with lock watchdog
module periph_bus_arbiter #(
  parameter int QUANTUM = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_rd,
  input  logic        m1_rd,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        err_clr,
  output logic [1:0]  timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] QUANT_LIM = CW'(QUANTUM - 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [1:0]      err_q, err_d;
  logic            owner;
  logic            own_req, own_lock, other_req, lock_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign owner     = (state_q == GNT1);
  assign own_req   = owner ? m1_req  : m0_req;
  assign own_lock  = owner ? m1_lock : m0_lock;
  assign other_req = owner ? m0_req  : m1_req;
  assign lock_expire = own_lock && (hold_q == LOCK_LIM);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    err_d   = err_clr ? 2'b00 : err_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        // On a tie the master that was not served last wins.
        if (m0_req && (!m1_req || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_req) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (lock_expire) err_d[owner] = 1'b1;
        if (!own_req || (!own_lock && other_req && hold_q >= QUANT_LIM) || lock_expire)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt      = (state_q == GNT0);
  assign m1_gnt      = (state_q == GNT1);
  assign timeout_err = err_q;

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    if (m0_gnt) begin
      rd    = m0_rd;
      wr    = m0_wr;
      addr  = m0_addr;
      wdata = m0_wdata;
    end else if (m1_gnt) begin
      rd    = m1_rd;
      wr    = m1_wr;
      addr  = m1_addr;
      wdata = m1_wdata;
    end
  end

  assign m0_ack   = m0_gnt & (m0_rd | m0_wr);
  assign m1_ack   = m1_gnt & (m1_rd | m1_wr);
  assign m0_rdata = (m0_gnt & m0_rd) ? rdata : 32'h0;
  assign m1_rdata = (m1_gnt & m1_rd) ? rdata : 32'h0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb/tb_periph_bus_arbiter.sv - directed and random checks of periph_bus_arbiter against a reference model
module tb_periph_bus_arbiter;

  localparam int QUANTUM = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, lock, rd_s, wr_s;
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];
  logic [31:0] prdata;
  logic        err_clr;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, how long they have had it, who was served last.
  int         owner;
  int         tenure;
  bit         last;
  logic [1:0] merr;

  periph_bus_arbiter #(.QUANTUM(QUANTUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m1_req(req[1]), .m0_lock(lock[0]), .m1_lock(lock[1]),
    .m0_rd(rd_s[0]), .m1_rd(rd_s[1]), .m0_wr(wr_s[0]), .m1_wr(wr_s[1]),
    .m0_addr(addr_s[0]), .m1_addr(addr_s[1]), .m0_wdata(wdata_s[0]), .m1_wdata(wdata_s[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(prdata),
    .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    tenure = 0;
    last   = 1'b1;
    merr   = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] nerr;
    int held;
    bit expire, release_bus;
    nerr = err_clr ? 2'b00 : merr;
    if (owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) owner = last ? 0 : 1;
        else owner = req[0] ? 0 : 1;
        last   = (owner == 1);
        tenure = 0;
      end
    end else begin
      held   = (tenure < TIMEOUT) ? tenure : TIMEOUT;
      expire = lock[owner] && (held == TIMEOUT - 1);
      release_bus = !req[owner] || (!lock[owner] && req[1-owner] && held >= QUANTUM - 1) || expire;
      if (expire) nerr[owner] = 1'b1;
      if (release_bus) owner = -1;
      else tenure++;
    end
    merr = nerr;
  endtask

  task automatic check_outputs();
    logic e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    if (owner >= 0) begin
      e_rd = rd_s[owner]; e_wr = wr_s[owner];
      e_addr = addr_s[owner]; e_wdata = wdata_s[owner];
    end
    chk("m0_gnt", m0_gnt, owner == 0);
    chk("m1_gnt", m1_gnt, owner == 1);
    chk("rd", rd, e_rd);
    chk("wr", wr, e_wr);
    chk("addr", addr, e_addr);
    chk("wdata", wdata, e_wdata);
    chk("m0_ack", m0_ack, (owner == 0) && (rd_s[0] || wr_s[0]));
    chk("m1_ack", m1_ack, (owner == 1) && (rd_s[1] || wr_s[1]));
    chk("m0_rdata", m0_rdata, ((owner == 0) && rd_s[0]) ? prdata : 32'h0);
    chk("m1_rdata", m1_rdata, ((owner == 1) && rd_s[1]) ? prdata : 32'h0);
    chk("timeout_err", timeout_err, merr);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic quiet();
    req = 2'b00; lock = 2'b00; rd_s = 2'b00; wr_s = 2'b00; err_clr = 1'b0;
    addr_s[0] = '0; addr_s[1] = '0; wdata_s[0] = '0; wdata_s[1] = '0; prdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    cyc(); cyc();
    reset = 1'b1;
    settle();
  endtask

  initial begin
    int n0;
    reset = 1'b0;
    quiet();
    model_reset();

    // Reset state
    #2;
    settle();
    cyc();
    settle();
    reset = 1'b1;
    cyc();
    settle();

    // Solo access
    cyc(); req = 2'b01; settle();
    chk("solo_no_comb_gnt", m0_gnt, 1'b0);
    cyc(); wr_s[0] = 1'b1; addr_s[0] = 32'h4000_000C; wdata_s[0] = 32'h0000_00A5; settle();
    chk("solo_gnt", m0_gnt, 1'b1);
    chk("solo_wr", wr, 1'b1);
    chk("solo_addr", addr, 32'h4000_000C);
    chk("solo_wdata", wdata, 32'h0000_00A5);
    chk("solo_ack", m0_ack, 1'b1);
    cyc(); quiet(); settle();
    cyc(); settle();
    chk("solo_release", m0_gnt, 1'b0);

    // Tie after reset: m0, IDLE, m1, then m0 again
    pulse_reset();
    cyc(); req = 2'b11; settle();
    for (int i = 0; i < 3; i++) begin
      cyc(); if (i == 2) req[0] = 1'b0; settle();
      chk("tie_m0", {m1_gnt, m0_gnt}, 2'b01);
    end
    cyc(); settle();
    chk("tie_idle", {m1_gnt, m0_gnt}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc(); if (i == 2) req[1] = 1'b0; settle();
      chk("tie_m1", {m1_gnt, m0_gnt}, 2'b10);
    end
    cyc(); req = 2'b11; settle();
    cyc(); settle();
    chk("tie_again_m0", {m1_gnt, m0_gnt}, 2'b01);
    cyc(); quiet(); settle();
    cyc(); settle();

    // Quantum under contention; m1 strobes while waiting must not leak
    cyc(); req = 2'b01; settle();
    cyc(); req = 2'b11; rd_s[1] = 1'b1; wr_s[1] = 1'b1; addr_s[1] = 32'h4000_0004; settle();
    n0 = 1;
    for (int i = 0; i < 30 && m0_gnt; i++) begin
      cyc(); settle();
      if (m0_gnt) n0++;
    end
    chk("quantum_len", n0, QUANTUM);
    chk("quantum_idle", {m1_gnt, m0_gnt}, 2'b00);
    cyc(); settle();
    chk("quantum_m1", m1_gnt, 1'b1);
    cyc(); quiet(); settle();
    cyc(); settle();
    cyc(); settle();

    // Lock timeout and err_clr
    cyc(); req = 2'b01; lock = 2'b01; settle();
    cyc(); req = 2'b11; settle();
    n0 = 1;
    for (int i = 0; i < 100 && m0_gnt; i++) begin
      cyc(); settle();
      if (m0_gnt) n0++;
    end
    chk("lock_len", n0, TIMEOUT);
    chk("lock_err", timeout_err, 2'b01);
    cyc(); req = 2'b00; lock = 2'b00; err_clr = 1'b1; settle();
    cyc(); err_clr = 1'b0; settle();
    chk("err_cleared", timeout_err, 2'b00);
    cyc(); settle();

    // Read routing to m1
    cyc(); req = 2'b10; settle();
    cyc(); rd_s[1] = 1'b1; addr_s[1] = 32'h4000_0010; prdata = 32'h0000_003C; settle();
    chk("read_m1_rdata", m1_rdata, 32'h0000_003C);
    chk("read_m0_rdata", m0_rdata, 32'h0);
    chk("read_addr", addr, 32'h4000_0010);

    // Reset mid-grant with a write in flight
    rd_s[1] = 1'b0; wr_s[1] = 1'b1; settle();
    reset = 1'b0;
    model_reset();
    settle();
    chk("rst_gnt", m1_gnt, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_ack", m1_ack, 1'b0);
    cyc(); reset = 1'b1; quiet(); req = 2'b11; settle();
    cyc(); settle();
    chk("post_reset_tie", {m1_gnt, m0_gnt}, 2'b01);
    cyc(); quiet(); settle();

    // Random traffic: fast-changing requests, then long locked tenures
    for (int i = 0; i < 3000; i++) begin
      int flip_req, flip_lock;
      flip_req  = (i < 1500) ? 8 : 150;
      flip_lock = (i < 1500) ? 16 : 40;
      cyc();
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(flip_req - 1) == 0) req[m] = ~req[m];
        if ($urandom_range(flip_lock - 1) == 0) lock[m] = ~lock[m];
        rd_s[m] = $urandom_range(1);
        wr_s[m] = $urandom_range(1);
        addr_s[m] = $urandom;
        wdata_s[m] = $urandom;
      end
      prdata = $urandom;
      err_clr = ($urandom_range(63) == 0);
      settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
